seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
Parametrised radix-2 shift-add multiplier for the calculator datapath. It is the successor to the fixed-function multiplier and adds four things: a start/ready/valid handshake, a full 2*inSize-bit product, a per-operation signed/unsigned mode, and a clock-enable stall. It sits between the operand registers and the result mux, and computes one product at a time over inSize iterations.

Parameters:
inSize, 8, operand width in bits (>=2)
CNT_W, $clog2(inSize+1), iteration counter width (derived; not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  clock enable; low freezes all state and outputs
start  input  1  request; accepted only when ready=1 and en=1
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
A  input  inSize  multiplicand, sampled with start
B  input  inSize  multiplier, sampled with start
ready  output  1  high only in IDLE
busy  output  1  high in CALC and DONE
product  output  2*inSize  result; holds last value until next DONE
valid  output  1  one-cycle pulse: product updated this cycle

Behaviour:
- Reset (rst=1 at an edge, regardless of en): state=IDLE, product=0, valid=0, busy=0, ready=1, internal registers cleared. Reset mid-operation abandons the operation; no valid is produced.
- FSM states:
  - IDLE: on start&en, latch the operands, the sign flag, and the result sign (A[msb]^B[msb] when is_signed, else 0). Operands become magnitudes: two's-complement negation when is_signed and msb=1, unsigned otherwise. Clear the accumulator, set counter=0, go to CALC.
  - CALC: each en-high cycle, if multiplier LSB=1 add the multiplicand magnitude into the upper half of a 2*inSize+1-bit accumulator. Then shift the accumulator and multiplier right by 1 and increment the counter. After exactly inSize iterations, go to DONE.
  - DONE: product <= result sign ? -acc : acc (low 2*inSize bits); valid=1 for this one cycle; next state IDLE.
- Latency with en held high: start accepted at edge k; valid high during the cycle after edge k+inSize+1. Minimum issue interval is inSize+2 cycles.
- en=0: state, counter, accumulator, product and valid all hold. Latency stretches by the number of stalled cycles. A valid pulse stays high until the first en-high edge.
- Handshake rules:
  - start while busy is ignored; no queueing.
  - start and rst in the same cycle: rst wins.
  - A, B and is_signed are don't-care outside the accepting cycle.
- Arithmetic:
  - Magnitude of the most-negative value (e.g. -128 at inSize=8) is 2^(inSize-1), representable in inSize unsigned bits.
  - Signed product range fits 2*inSize bits: (-128)*(-128) = +16384.
  - A zero operand yields 0 with no sign flip; -0 is never produced.
- ready = (state==IDLE); busy = !ready. Both are registered-state decodes with no combinational path from start.

Decomposition:
- Shared package calc_pkg:
  - mul_state_t enum {IDLE, CALC, DONE}
  - localparam helper for CNT_W
  - common opcode/sign-mode constants reused by the adder and divider
- One sub-module, twos_abs (parametrised width, combinational conditional negate). Instantiated twice for operand magnitudes and once, at 2*inSize, for the result sign fix.

Test Plan:
1. inSize=8, unsigned, A=13, B=11, start one cycle at edge k, en=1 -> valid only at cycle k+9, product=0x008F, ready returns at k+10.
2. Signed cases:
   - A=0xFD (-3), B=0x05 -> product=0xFFF1
   - A=0x80, B=0x80 -> 0x4000
   - A=0x80, B=0x01 -> 0xFF80
3. Unsigned A=0xFF, B=0xFF -> 0xFE01; then signed with the same operands -> 0x0001; A=0, B=0xFF signed -> 0x0000.
4. Stall and busy start: drop en for 3 cycles mid-CALC with A=7, B=6 unsigned -> valid at k+12, product=42. A second start pulse while busy -> ignored, exactly one valid.
5. Reset mid-op: assert rst 4 cycles into CALC -> next cycle ready=1, product=0, no valid pulse. A new start with A=2, B=3 -> product=6.
6. Parameter sweep at inSize=4: 15*15 unsigned -> 0xE1; -8*7 signed -> 0xC8; valid at k+5.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the calculator datapath units
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } calc_op_t;

  localparam logic SIGN_MODE_UNSIGNED = 1'b0;
  localparam logic SIGN_MODE_SIGNED   = 1'b1;

  // Counter must hold the value n itself, not just n-1.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/twos_abs.sv
// rtl/twos_abs.sv - combinational conditional two's-complement negate
module twos_abs #(
  parameter int W = 8
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - radix-2 shift-add multiplier, signed/unsigned, with stall
module seq_multiplier
  import calc_pkg::*;
#(
  parameter int inSize = 8,
  parameter int CNT_W  = cnt_width(inSize)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                start,
  input  logic                is_signed,
  input  logic [inSize-1:0]   A,
  input  logic [inSize-1:0]   B,
  output logic                ready,
  output logic                busy,
  output logic [2*inSize-1:0] product,
  output logic                valid
);

  localparam int N = inSize;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);

  mul_state_t       state, state_n;
  logic [N-1:0]     mcand, mplier;
  logic [2*N:0]     acc, acc_shift;
  logic [N:0]       upper;
  logic [CNT_W-1:0] cnt;
  logic             res_sign;
  logic [N-1:0]     mag_a, mag_b;
  logic [2*N-1:0]   fixed;

  twos_abs #(.W(N)) u_abs_a (
    .value (A),
    .negate(is_signed & A[N-1]),
    .result(mag_a)
  );

  twos_abs #(.W(N)) u_abs_b (
    .value (B),
    .negate(is_signed & B[N-1]),
    .result(mag_b)
  );

  // Negating a zero magnitude yields zero, so no -0 can appear.
  twos_abs #(.W(2*N)) u_fix (
    .value (acc[2*N-1:0]),
    .negate(res_sign),
    .result(fixed)
  );

  assign upper     = mplier[0] ? (acc[2*N:N] + {1'b0, mcand}) : acc[2*N:N];
  assign acc_shift = {upper, acc[N-1:0]} >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (en) begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = CALC;
      CALC:    if (cnt == LAST_ITER) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      res_sign <= 1'b0;
      product  <= '0;
      valid    <= 1'b0;
    end else if (en) begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand    <= mag_a;
            mplier   <= mag_b;
            res_sign <= is_signed & (A[N-1] ^ B[N-1]);
            acc      <= '0;
            cnt      <= '0;
          end
        end
        CALC: begin
          acc    <= acc_shift;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        DONE: begin
          product <= fixed;
          valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = ~ready;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - directed self-checking bench for seq_multiplier
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        start8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ready8, busy8, valid8;
  logic [15:0] prod8;
  logic        start4 = 1'b0, sgn4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        ready4, busy4, valid4;
  logic [7:0]  prod4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.inSize(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .start(start8), .is_signed(sgn8),
    .A(a8), .B(b8), .ready(ready8), .busy(busy8), .product(prod8), .valid(valid8)
  );

  seq_multiplier #(.inSize(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .start(start4), .is_signed(sgn4),
    .A(a4), .B(b4), .ready(ready4), .busy(busy4), .product(prod4), .valid(valid4)
  );

  // Issue one op; loop index i means "just after edge k+i" where k accepts start.
  task automatic do_op(input bit use4, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input int stall_at, input int stall_len,
                       input int bstart_at, output logic [15:0] p, output int lat,
                       output int nvalid, output logic rdy_mid, output logic rdy_v);
    logic v;
    lat = -1; nvalid = 0; p = '0; rdy_mid = 1'bx; rdy_v = 1'bx;
    if (use4) begin a4 = a[3:0]; b4 = b[3:0]; sgn4 = s; start4 = 1'b1; end
    else begin a8 = a; b8 = b; sgn8 = s; start8 = 1'b1; end
    @(posedge clk); #1;
    start4 = 1'b0; start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
    a4 = 4'($urandom); b4 = 4'($urandom); sgn4 = 1'($urandom);
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      v = use4 ? valid4 : valid8;
      if (i == 2) rdy_mid = use4 ? ready4 : ready8;
      if (v) begin
        nvalid++;
        if (lat < 0) begin
          lat = i;
          p = use4 ? {8'h00, prod4} : prod8;
          rdy_v = use4 ? ready4 : ready8;
        end
      end
      if (i == stall_at) en = 1'b0;
      if (i == stall_at + stall_len) en = 1'b1;
      if (i == bstart_at) begin
        if (use4) start4 = 1'b1; else start8 = 1'b1;
      end else begin
        start4 = 1'b0; start8 = 1'b0;
      end
    end
    en = 1'b1; start4 = 1'b0; start8 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready8 !== 1'b1) begin errors++; $display("FAIL reset_ready8 got=%b exp=1", ready8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8 got=%b exp=0", busy8); end
    checks++; if (valid8 !== 1'b0) begin errors++; $display("FAIL reset_valid8 got=%b exp=0", valid8); end
    checks++; if (prod8 !== 16'h0000) begin errors++; $display("FAIL reset_prod8 got=%h exp=0000", prod8); end
    checks++; if (ready4 !== 1'b1 || prod4 !== 8'h00) begin errors++; $display("FAIL reset_dut4 got ready=%b prod=%h exp ready=1 prod=00", ready4, prod4); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] p; int lat, nv; logic rm, rv;
    do_op(1'b0, 8'd13, 8'd11, 1'b0, 0, 0, 0, p, lat, nv, rm, rv);
    checks++; if (p !== 16'h008F) begin errors++; $display("FAIL basic_prod got=%h exp=008f", p); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency got=%0d exp=9", lat); end
    checks++; if (nv !== 1) begin errors++; $display("FAIL basic_nvalid got=%0d exp=1", nv); end
    checks++; if (rm !== 1'b0) begin errors++; $display("FAIL basic_ready_busy got=%b exp=0", rm); end
    checks++; if (rv !== 1'b1) begin errors++; $display("FAIL basic_ready_back got=%b exp=1", rv); end
  endtask

  task automatic test_signed();
    logic [7:0]  va [6] = '{8'hFD, 8'h80, 8'h80, 8'hFF, 8'hFF, 8'h00};
    logic [7:0]  vb [6] = '{8'h05, 8'h80, 8'h01, 8'hFF, 8'hFF, 8'hFF};
    logic        vs [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [15:0] ve [6] = '{16'hFFF1, 16'h4000, 16'hFF80, 16'hFE01, 16'h0001, 16'h0000};
    logic [15:0] p; int lat, nv; logic rm, rv;
    for (int i = 0; i < 6; i++) begin
      do_op(1'b0, va[i], vb[i], vs[i], 0, 0, 0, p, lat, nv, rm, rv);
      checks++;
      if (p !== ve[i] || lat !== 9) begin
        errors++;
        $display("FAIL arith_%0d a=%h b=%h s=%b got=%h lat=%0d exp=%h lat=9", i, va[i], vb[i], vs[i], p, lat, ve[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] p; int lat, nv; logic rm, rv;
    do_op(1'b0, 8'd7, 8'd6, 1'b0, 3, 3, 0, p, lat, nv, rm, rv);
    checks++; if (p !== 16'd42) begin errors++; $display("FAIL stall_prod got=%0d exp=42", p); end
    checks++; if (lat !== 12) begin errors++; $display("FAIL stall_latency got=%0d exp=12", lat); end
  endtask

  task automatic test_busy_start();
    logic [15:0] p; int lat, nv; logic rm, rv;
    do_op(1'b0, 8'd9, 8'd10, 1'b0, 0, 0, 3, p, lat, nv, rm, rv);
    checks++; if (p !== 16'd90 || lat !== 9) begin errors++; $display("FAIL busy_start_prod got=%0d lat=%0d exp=90 lat=9", p, lat); end
    checks++; if (nv !== 1) begin errors++; $display("FAIL busy_start_nvalid got=%0d exp=1", nv); end
  endtask

  task automatic test_valid_hold();
    int n;
    a8 = 8'd3; b8 = 8'd4; sgn8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    n = 0;
    while (valid8 !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (valid8 !== 1'b1) begin errors++; $display("FAIL hold_valid_seen got=%b exp=1", valid8); end
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (valid8 !== 1'b1 || prod8 !== 16'd12) begin errors++; $display("FAIL hold_stalled got valid=%b prod=%0d exp valid=1 prod=12", valid8, prod8); end
    en = 1'b1;
    @(posedge clk); #1;
    checks++; if (valid8 !== 1'b0) begin errors++; $display("FAIL hold_release got=%b exp=0", valid8); end
  endtask

  task automatic test_reset_midop();
    logic [15:0] p; int lat, nv; logic rm, rv;
    int seen;
    a8 = 8'h55; b8 = 8'h33; sgn8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1; start8 = 1'b1;
    @(posedge clk); #1; rst = 1'b0; start8 = 1'b0;
    checks++; if (ready8 !== 1'b1 || prod8 !== 16'h0000 || valid8 !== 1'b0) begin
      errors++; $display("FAIL midop_reset got ready=%b prod=%h valid=%b exp ready=1 prod=0000 valid=0", ready8, prod8, valid8);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin @(posedge clk); #1; if (valid8 === 1'b1) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midop_no_valid got=%0d exp=0", seen); end
    do_op(1'b0, 8'd2, 8'd3, 1'b0, 0, 0, 0, p, lat, nv, rm, rv);
    checks++; if (p !== 16'd6 || lat !== 9) begin errors++; $display("FAIL midop_after got=%0d lat=%0d exp=6 lat=9", p, lat); end
  endtask

  task automatic test_width4();
    logic [15:0] p; int lat, nv; logic rm, rv;
    do_op(1'b1, 8'h0F, 8'h0F, 1'b0, 0, 0, 0, p, lat, nv, rm, rv);
    checks++; if (p !== 16'h00E1) begin errors++; $display("FAIL w4_unsigned got=%h exp=00e1", p); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL w4_latency got=%0d exp=5", lat); end
    do_op(1'b1, 8'h08, 8'h07, 1'b1, 0, 0, 0, p, lat, nv, rm, rv);
    checks++; if (p !== 16'h00C8 || lat !== 5) begin errors++; $display("FAIL w4_signed got=%h lat=%0d exp=00c8 lat=5", p, lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_stall();
    test_busy_start();
    test_valid_hold();
    test_reset_midop();
    test_width4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=stuck exp=finish");
    $fatal(1, "timeout");
  end

endmodule
